// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
// The fetch sequencer is the master; the instruction memory is the slave.
interface if_fetch_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues word-aligned fetches, keeps a
// one-entry skid buffer for ID freezes and discards fetches made stale by a redirect.
module if_fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                INSTR_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_freeze,
   input  logic                i_branch_taken,
   input  logic [ADDR_W-1:0]   i_branch_addr,
   if_fetch_ctrl_if.master     bus,
   output logic                o_if_valid,
   output logic [ADDR_W-1:0]   o_if_pc,
   output logic [INSTR_W-1:0]  o_if_instr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_DROP
   } state_t;

   state_t              r_state;
   logic                r_mem_req;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_req_addr;
   logic [ADDR_W-1:0]   r_skid_pc;
   logic [INSTR_W-1:0]  r_skid_instr;
   logic                r_if_valid;
   logic [ADDR_W-1:0]   r_if_pc;
   logic [INSTR_W-1:0]  r_if_instr;

   logic [ADDR_W-1:0]   w_target;
   logic [ADDR_W-1:0]   w_req_next;
   logic                w_slot_free;
   logic                w_consume;
   logic                w_unused_addr_bits;

   assign w_target           = {i_branch_addr[ADDR_W-1:2], 2'b00};
   assign w_unused_addr_bits = &{1'b0, i_branch_addr[1:0]};
   // Wraps modulo 2^ADDR_W, so a fetch at the top word continues at zero.
   assign w_req_next         = r_req_addr + ADDR_W'(4);
   assign w_slot_free        = !r_if_valid || !i_freeze;
   assign w_consume          = r_if_valid && !i_freeze;

   // NOTE: all state uses non-blocking assignments; when a register is assigned
   // twice in one pass the later assignment wins, which gives the flush its priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_mem_req    <= 1'b0;
         r_pc         <= RESET_PC;
         r_req_addr   <= RESET_PC;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_if_valid   <= 1'b0;
         r_if_pc      <= '0;
         r_if_instr   <= '0;
      end else begin
         if (w_consume) begin
            r_if_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_state   <= S_FETCH;
               r_mem_req <= 1'b1;
               if (i_branch_taken) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
               end else begin
                  r_req_addr <= r_pc;
               end
            end

            S_FETCH: begin
               if (bus.mem_ack) begin
                  if (i_branch_taken) begin
                     r_pc       <= w_target;
                     r_req_addr <= w_target;
                  end else if (w_slot_free) begin
                     r_if_valid <= 1'b1;
                     r_if_pc    <= w_req_next;
                     r_if_instr <= bus.mem_rdata;
                     r_pc       <= w_req_next;
                     r_req_addr <= w_req_next;
                  end else begin
                     // ID is frozen on a valid slot: park the word and stop requesting.
                     r_skid_instr <= bus.mem_rdata;
                     r_skid_pc    <= w_req_next;
                     r_pc         <= w_req_next;
                     r_state      <= S_HOLD;
                     r_mem_req    <= 1'b0;
                  end
               end else if (i_branch_taken) begin
                  // The request cannot be withdrawn; keep it up and discard its data.
                  r_pc    <= w_target;
                  r_state <= S_DROP;
               end
            end

            S_HOLD: begin
               if (i_branch_taken) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
                  r_state    <= S_FETCH;
                  r_mem_req  <= 1'b1;
               end else if (w_slot_free) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= r_skid_pc;
                  r_if_instr <= r_skid_instr;
                  r_req_addr <= r_pc;
                  r_state    <= S_FETCH;
                  r_mem_req  <= 1'b1;
               end
            end

            S_DROP: begin
               if (i_branch_taken) begin
                  r_pc <= w_target;
               end
               if (bus.mem_ack) begin
                  r_req_addr <= i_branch_taken ? w_target : r_pc;
                  r_state    <= S_FETCH;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase

         if (i_branch_taken) begin
            r_if_valid <= 1'b0;
         end
      end
   end

   assign bus.mem_req  = r_mem_req;
   assign bus.mem_addr = r_req_addr;
   assign o_if_valid   = r_if_valid;
   assign o_if_pc      = r_if_pc;
   assign o_if_instr   = r_if_instr;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: streaming, freeze/skid, redirect under latency,
// flush with freeze, PC wrap and asynchronous reset mid-request.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch;
   logic [31:0] branch_addr;
   logic        valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        valid2;
   logic [31:0] if_pc2;
   logic [31:0] if_instr2;

   int          lat;
   logic        force_ack;
   int          wait_cnt;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   if_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus0 ();
   if_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus1 ();

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model for the main DUT: ack after lat wait cycles; force_ack drives a stray ack.
   always @(posedge clk or posedge rst) begin
      if (rst)                                 wait_cnt <= 0;
      else if (bus0.mem_ack || !bus0.mem_req)  wait_cnt <= 0;
      else                                     wait_cnt <= wait_cnt + 1;
   end
   assign bus0.mem_ack   = force_ack || (bus0.mem_req && (wait_cnt >= lat));
   assign bus0.mem_rdata = force_ack ? 32'hBADB_AD00 : word(bus0.mem_addr);

   assign bus1.mem_ack   = bus1.mem_req;
   assign bus1.mem_rdata = word(bus1.mem_addr);

   if_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .INSTR_W(32)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_freeze       (freeze),
      .i_branch_taken (branch),
      .i_branch_addr  (branch_addr),
      .bus            (bus0),
      .o_if_valid     (valid),
      .o_if_pc        (if_pc),
      .o_if_instr     (if_instr)
   );

   if_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .INSTR_W(32)) u_dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .i_freeze       (1'b0),
      .i_branch_taken (1'b0),
      .i_branch_addr  (32'h0),
      .bus            (bus1),
      .o_if_valid     (valid2),
      .o_if_pc        (if_pc2),
      .o_if_instr     (if_instr2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      freeze      = 1'b0;
      branch      = 1'b0;
      branch_addr = 32'h0;
      force_ack   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      lat         = 0;
      rst         = 1'b1;
      freeze      = 1'b0;
      branch      = 1'b0;
      branch_addr = 32'h0;
      force_ack   = 1'b0;
      tick();
      n_total++; if (bus0.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus0.mem_req); else n_pass++;
      n_total++; if (bus0.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 00000000", bus0.mem_addr); else n_pass++;
      n_total++; if (valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", valid); else n_pass++;
      n_total++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 00000000", if_pc); else n_pass++;
      n_total++; if (if_instr !== 32'h0) $display("FAIL reset_if_instr: got %h want 00000000", if_instr); else n_pass++;
      n_total++; if (bus1.mem_addr !== 32'hFFFF_FFFC) $display("FAIL reset_wrap_addr: got %h want fffffffc", bus1.mem_addr); else n_pass++;
      rst = 1'b0;
      tick();
      n_total++; if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0)
         $display("FAIL idle_to_fetch: got req=%b addr=%h want req=1 addr=00000000", bus0.mem_req, bus0.mem_addr); else n_pass++;
   endtask

   task automatic test_stream();
      lat = 0;
      do_reset();
      tick();
      n_total++; if (bus0.mem_addr !== 32'h0 || valid !== 1'b0)
         $display("FAIL stream_first: got addr=%h valid=%b want addr=00000000 valid=0", bus0.mem_addr, valid); else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_total++; if (bus0.mem_addr !== 32'(4 * i))
            $display("FAIL stream_addr[%0d]: got %h want %h", i, bus0.mem_addr, 32'(4 * i)); else n_pass++;
         n_total++; if (valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== word(32'(4 * (i - 1))))
            $display("FAIL stream_slot[%0d]: got valid=%b pc=%h instr=%h want 1 %h %h",
                     i, valid, if_pc, if_instr, 32'(4 * i), word(32'(4 * (i - 1)))); else n_pass++;
      end
   endtask

   task automatic test_freeze_skid();
      lat = 0;
      do_reset();
      tick();
      tick();
      tick();
      n_total++; if (if_pc !== 32'h8 || if_instr !== word(32'h4) || bus0.mem_addr !== 32'h8)
         $display("FAIL freeze_pre: got pc=%h instr=%h addr=%h want 00000008 %h 00000008",
                  if_pc, if_instr, bus0.mem_addr, word(32'h4)); else n_pass++;
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (bus0.mem_req !== 1'b0 || valid !== 1'b1 || if_instr !== word(32'h4))
            $display("FAIL freeze_hold[%0d]: got req=%b valid=%b instr=%h want 0 1 %h",
                     i, bus0.mem_req, valid, if_instr, word(32'h4)); else n_pass++;
      end
      freeze = 1'b0;
      tick();
      n_total++; if (valid !== 1'b1 || if_pc !== 32'hC || if_instr !== word(32'h8))
         $display("FAIL freeze_skid_out: got valid=%b pc=%h instr=%h want 1 0000000c %h",
                  valid, if_pc, if_instr, word(32'h8)); else n_pass++;
      n_total++; if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'hC)
         $display("FAIL freeze_refetch: got req=%b addr=%h want 1 0000000c", bus0.mem_req, bus0.mem_addr); else n_pass++;
      tick();
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== word(32'hC))
         $display("FAIL freeze_next: got valid=%b pc=%h instr=%h want 1 00000010 %h",
                  valid, if_pc, if_instr, word(32'hC)); else n_pass++;
   endtask

   task automatic test_branch_latency();
      int n;
      lat = 3;
      do_reset();
      tick();
      branch      = 1'b1;
      branch_addr = 32'h43;
      tick();
      branch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_total++; if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0 || valid !== 1'b0)
            $display("FAIL drop_wait[%0d]: got req=%b addr=%h valid=%b want 1 00000000 0",
                     i, bus0.mem_req, bus0.mem_addr, valid); else n_pass++;
         tick();
      end
      n_total++; if (bus0.mem_addr !== 32'h40 || bus0.mem_req !== 1'b1 || valid !== 1'b0)
         $display("FAIL drop_redirect: got addr=%h req=%b valid=%b want 00000040 1 0",
                  bus0.mem_addr, bus0.mem_req, valid); else n_pass++;
      n = 0;
      while (!valid && n < 10) begin
         tick();
         n++;
      end
      n_total++; if (n !== 4)
         $display("FAIL drop_latency: got %0d cycles want 4", n); else n_pass++;
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== word(32'h40))
         $display("FAIL drop_target_word: got valid=%b pc=%h instr=%h want 1 00000044 %h",
                  valid, if_pc, if_instr, word(32'h40)); else n_pass++;
   endtask

   task automatic test_flush_with_freeze();
      lat = 0;
      do_reset();
      tick();
      tick();
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h4 || bus0.mem_addr !== 32'h4)
         $display("FAIL flush_pre: got valid=%b pc=%h addr=%h want 1 00000004 00000004",
                  valid, if_pc, bus0.mem_addr); else n_pass++;
      freeze      = 1'b1;
      branch      = 1'b1;
      branch_addr = 32'h101;
      tick();
      branch = 1'b0;
      n_total++; if (valid !== 1'b0)
         $display("FAIL flush_valid: got %b want 0", valid); else n_pass++;
      n_total++; if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h100)
         $display("FAIL flush_target: got req=%b addr=%h want 1 00000100", bus0.mem_req, bus0.mem_addr); else n_pass++;
      tick();
      freeze = 1'b0;
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== word(32'h100))
         $display("FAIL flush_first: got valid=%b pc=%h instr=%h want 1 00000104 %h",
                  valid, if_pc, if_instr, word(32'h100)); else n_pass++;
      tick();
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h108 || if_instr !== word(32'h104))
         $display("FAIL flush_second: got valid=%b pc=%h instr=%h want 1 00000108 %h",
                  valid, if_pc, if_instr, word(32'h104)); else n_pass++;
   endtask

   task automatic test_wrap();
      lat = 0;
      do_reset();
      tick();
      n_total++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 32'hFFFF_FFFC)
         $display("FAIL wrap_first_addr: got req=%b addr=%h want 1 fffffffc", bus1.mem_req, bus1.mem_addr); else n_pass++;
      tick();
      n_total++; if (valid2 !== 1'b1 || if_pc2 !== 32'h0 || if_instr2 !== word(32'hFFFF_FFFC))
         $display("FAIL wrap_if_pc: got valid=%b pc=%h instr=%h want 1 00000000 %h",
                  valid2, if_pc2, if_instr2, word(32'hFFFF_FFFC)); else n_pass++;
      n_total++; if (bus1.mem_addr !== 32'h0)
         $display("FAIL wrap_second_addr: got %h want 00000000", bus1.mem_addr); else n_pass++;
   endtask

   task automatic test_async_reset();
      lat = 0;
      do_reset();
      tick();
      tick();
      lat    = 3;
      freeze = 1'b1;
      tick();
      n_total++; if (valid !== 1'b1 || bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h4)
         $display("FAIL areset_pre: got valid=%b req=%b addr=%h want 1 1 00000004",
                  valid, bus0.mem_req, bus0.mem_addr); else n_pass++;
      #2;
      rst    = 1'b1;
      freeze = 1'b0;
      #1;
      n_total++; if (bus0.mem_req !== 1'b0 || bus0.mem_addr !== 32'h0 || valid !== 1'b0 ||
                     if_pc !== 32'h0 || if_instr !== 32'h0)
         $display("FAIL areset_outputs: got req=%b addr=%h valid=%b pc=%h instr=%h want all zero",
                  bus0.mem_req, bus0.mem_addr, valid, if_pc, if_instr); else n_pass++;
      lat = 0;
      tick();
      rst       = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      n_total++; if (valid !== 1'b0 || bus0.mem_req !== 1'b1 || bus0.mem_addr !== 32'h0)
         $display("FAIL areset_idle_ack: got valid=%b req=%b addr=%h want 0 1 00000000",
                  valid, bus0.mem_req, bus0.mem_addr); else n_pass++;
      tick();
      n_total++; if (valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== word(32'h0))
         $display("FAIL areset_first_word: got valid=%b pc=%h instr=%h want 1 00000004 %h",
                  valid, if_pc, if_instr, word(32'h0)); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_freeze_skid();
      test_branch_latency();
      test_flush_with_freeze();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the PC logic and the instruction memory in the IF stage. Owns the PC and issues word-aligned fetch requests over a req/ack handshake. Tolerates variable memory latency. Buffers one instruction when ID is frozen, and discards in-flight fetches on branch redirect. Drives the IF/ID register (valid, pc, instruction).

Parameters:
ADDR_W, 32, width of PC, memory address and branch target
RESET_PC, 32'h0000_0000, first fetch address after reset
INSTR_W, 32, instruction width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
freeze  input  1  hazard stall from ID; the IF/ID slot is not consumed this cycle
branch_taken  input  1  redirect/flush request from EXE, single-cycle pulse
branch_addr  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
mem_req  output  1  fetch request to instruction memory
mem_addr  output  ADDR_W  fetch address, word aligned
mem_ack  input  1  memory response valid; sampled only while mem_req=1
mem_rdata  input  INSTR_W  instruction word, valid when mem_ack=1
if_valid  output  1  IF/ID slot holds a valid instruction
if_pc  output  ADDR_W  fetched address + 4 (ARM-style PC for ID)
if_instr  output  INSTR_W  fetched instruction

Behaviour:
- Registers:
  - pc: next fetch target.
  - req_addr: address of the outstanding request; drives mem_addr.
  - skid_instr / skid_pc: one-entry buffer.
  - if_*: the IF/ID slot.
  - state: IDLE, FETCH, HOLD, DROP.
- Reset (async, any time, including mid-request): state=IDLE, pc=req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, skid cleared, mem_req=0. An outstanding request is abandoned, and the memory must tolerate this.
- mem_req = (state==FETCH || state==DROP). mem_addr = req_addr. While mem_req=1 without ack, mem_addr is held stable.
- Slot consumption: the slot is consumed at a clock edge when if_valid=1 && freeze=0. "Slot free" = !if_valid || !freeze.
- IDLE: next edge goes to FETCH, with req_addr=pc.
- FETCH, ack=1:
  - branch_taken=1: drop the data, pc=req_addr=branch_addr&~3, stay in FETCH.
  - Slot free: if_instr=mem_rdata, if_pc=req_addr+4, if_valid=1, pc=req_addr=req_addr+4, stay in FETCH. This gives back-to-back fetches at 1/cycle when ack is combinational.
  - Slot not free: skid=(mem_rdata, req_addr+4), pc=req_addr+4, go to HOLD.
- FETCH, ack=0:
  - branch_taken=1: pc=branch_addr&~3, go to DROP. req_addr is unchanged.
  - Otherwise: wait in FETCH.
- HOLD (mem_req=0):
  - branch_taken=1: discard the skid, req_addr=pc=branch_addr&~3, go to FETCH.
  - Slot free: move the skid into if_*, if_valid=1, req_addr=pc, go to FETCH.
  - Otherwise: stay in HOLD.
- DROP:
  - On ack: discard mem_rdata, req_addr=pc, go to FETCH.
  - A further branch_taken in DROP (with or without ack) overwrites pc with the newest target.
- Flush: branch_taken=1 clears if_valid at that edge in every state. Flush has priority over freeze and over any load into the slot.
- Slot consumed with nothing to load: if_valid goes to 0.
- Arithmetic: the +4 is modulo 2^ADDR_W (32'hFFFF_FFFC+4 = 0).
- Nothing in IF/ID is ever duplicated or skipped; order equals fetch order.

Test Plan:
1. Reset, then memory with ack in the same cycle, freeze=0 -> mem_addr sequence 0,4,8,C on consecutive cycles; if_pc 4,8,C,10 one cycle later; if_valid=1 from cycle 2 on.
2. freeze=1 for 3 cycles while ack arrives -> if_instr holds the word at 0x4, the word at 0x8 goes to the skid, mem_req=0 during HOLD. After release, 0x8 then 0xC appear in order with no loss.
3. Memory latency of 3 cycles, branch_taken with branch_addr=0x43 in the 1st wait cycle -> mem_addr stays at the old address until ack. The ack data is dropped, the next request is 0x40, and if_valid=0 until the 0x40 word returns.
4. branch_taken together with ack and freeze=1 -> if_valid=0 next cycle, the skid is unused, the next mem_addr is the target.
5. RESET_PC=32'hFFFF_FFFC -> first if_pc=0x0, second mem_addr=0x0 (wrap).
6. Assert rst mid-wait (mem_req=1, no ack) -> outputs go to zero immediately (async). After release, the first request is at RESET_PC, and a late ack during IDLE is ignored.
